// File: rtl/dmem_arbiter_pkg.sv
// rtl/dmem_arbiter_pkg.sv - shared types for the dual-core data memory arbiter
package dmem_arbiter_pkg;

   localparam int NUM_CORES = 2;
   localparam int WORD_W    = 32;

   typedef logic [WORD_W-1:0] word_t;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } arb_state_t;

   // Priority to hand over once a core has been served: the core that was not granted.
   function automatic logic next_prio(input logic [NUM_CORES-1:0] served);
      return served[0];
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - combinational two-way round-robin pick, priority held by caller
module rr_arb2
   import dmem_arbiter_pkg::*;
(
   input  logic [NUM_CORES-1:0] req,
   input  logic                 prio,
   output logic [NUM_CORES-1:0] gnt
);

   always_comb begin
      gnt = '0;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = prio ? 2'b10 : 2'b01;
         default: gnt = '0;
      endcase
   end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - shares one fixed-latency data memory between two cores
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int MEM_LAT = 1,
   parameter int CNT_W   = 4
)
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NUM_CORES-1:0] req,
   input  logic [NUM_CORES-1:0] we,
   input  word_t                addr0,
   input  word_t                addr1,
   input  word_t                wdata0,
   input  word_t                wdata1,
   output logic [NUM_CORES-1:0] done,
   output word_t                rdata0,
   output word_t                rdata1,
   output logic [NUM_CORES-1:0] gnt,
   output logic                 mem_en,
   output logic                 mem_we,
   output word_t                mem_addr,
   output word_t                mem_wdata,
   input  word_t                mem_rdata
);

   arb_state_t             state;
   arb_state_t             state_next;
   logic                   prio;
   logic [NUM_CORES-1:0]   pick;
   logic [CNT_W-1:0]       cnt;

   rr_arb2 u_rr_arb2 (
      .req  (req),
      .prio (prio),
      .gnt  (pick)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      mem_en     = 1'b0;
      done       = '0;
      case (state)
         IDLE: begin
            if (|req) begin
               state_next = ISSUE;
            end
         end
         ISSUE: begin
            mem_en     = 1'b1;
            state_next = WAIT;
         end
         WAIT: begin
            if (cnt == '0) begin
               state_next = RESP;
            end
         end
         RESP: begin
            done       = gnt;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Request fields are captured once in IDLE so later changes by a stalled core are ignored.
   always_ff @(posedge clk) begin
      if (reset) begin
         gnt       <= '0;
         prio      <= 1'b0;
         cnt       <= '0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         rdata0    <= '0;
         rdata1    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (|req) begin
                  gnt       <= pick;
                  mem_we    <= |(pick & we);
                  mem_addr  <= pick[1] ? addr1 : addr0;
                  mem_wdata <= pick[1] ? wdata1 : wdata0;
               end
            end
            ISSUE: begin
               cnt <= CNT_W'(MEM_LAT - 1);
            end
            WAIT: begin
               if (cnt == '0) begin
                  if (!mem_we && gnt[0]) begin
                     rdata0 <= mem_rdata;
                  end
                  if (!mem_we && gnt[1]) begin
                     rdata1 <= mem_rdata;
                  end
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            RESP: begin
               prio <= next_prio(gnt);
               gnt  <= '0;
            end
            default: begin
               gnt <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter at MEM_LAT 1 and 3
module tb_dmem_arbiter;
   import dmem_arbiter_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset;
   logic       req0_r, req1_r, we0_r, we1_r;
   logic [1:0] req, we;
   assign req = {req1_r, req0_r};
   assign we  = {we1_r, we0_r};
   word_t      addr0, addr1, wdata0, wdata1;
   logic [1:0] done, gnt;
   word_t      rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;
   logic       mem_en, mem_we;

   logic [1:0] req_l, we_l, done_l, gnt_l;
   word_t      rdata0_l, rdata1_l, mem_addr_l, mem_wdata_l, mem_rdata_l;
   logic       mem_en_l, mem_we_l;

   dmem_arbiter #(.MEM_LAT(1), .CNT_W(4)) dut (
      .clk(clk), .reset(reset), .req(req), .we(we),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .done(done), .rdata0(rdata0), .rdata1(rdata1), .gnt(gnt),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   dmem_arbiter #(.MEM_LAT(3), .CNT_W(4)) dut3 (
      .clk(clk), .reset(reset), .req(req_l), .we(we_l),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .done(done_l), .rdata0(rdata0_l), .rdata1(rdata1_l), .gnt(gnt_l),
      .mem_en(mem_en_l), .mem_we(mem_we_l), .mem_addr(mem_addr_l),
      .mem_wdata(mem_wdata_l), .mem_rdata(mem_rdata_l)
   );

   int total = 0;
   int bad = 0;
   int viol_cnt = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   function automatic word_t init_word(input int i);
      if (i == 16) return 32'hDEADBEEF;
      return 32'h1000_0000 + word_t'(i) * 32'h0001_0011;
   endfunction

   // Memory models: data only shows on mem_rdata in the single cycle it is valid.
   logic  mem_init;
   word_t mem1 [256];
   word_t mem3 [256];
   logic  v1, v3a, v3b, v3c;
   word_t d1, d3a, d3b, d3c;
   assign mem_rdata   = v1  ? d1  : 32'hBADBAD01;
   assign mem_rdata_l = v3c ? d3c : 32'hBADBAD03;

   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 256; i++) begin
            mem1[i] <= init_word(i);
            mem3[i] <= init_word(i);
         end
         v1 <= 1'b0; v3a <= 1'b0; v3b <= 1'b0; v3c <= 1'b0;
         d1 <= '0; d3a <= '0; d3b <= '0; d3c <= '0;
      end else begin
         if (mem_en && mem_we) mem1[mem_addr[9:2]] <= mem_wdata;
         if (mem_en_l && mem_we_l) mem3[mem_addr_l[9:2]] <= mem_wdata_l;
         v1  <= mem_en && !mem_we;
         d1  <= mem1[mem_addr[9:2]];
         v3a <= mem_en_l && !mem_we_l;
         d3a <= mem3[mem_addr_l[9:2]];
         v3b <= v3a; d3b <= d3a;
         v3c <= v3b; d3c <= d3b;
      end
   end

   typedef struct {
      logic [1:0] done;
      logic       load;
      word_t      data;
   } exp_t;
   exp_t  sbq [$];
   word_t ref_mem [256];
   word_t exp_rd0 = '0;
   word_t exp_rd1 = '0;

   task automatic push_exp(input int c, input logic w, input word_t a, input word_t d);
      exp_t e;
      e.done = (c == 0) ? 2'b01 : 2'b10;
      e.load = !w;
      if (w) begin
         ref_mem[a[9:2]] = d;
         e.data = d;
      end else begin
         e.data = ref_mem[a[9:2]];
      end
      sbq.push_back(e);
   endtask

   always @(negedge clk) begin
      if (reset) begin
         exp_rd0 <= '0;
         exp_rd1 <= '0;
      end else if (done != 2'b00) begin
         if (sbq.size() == 0) begin
            chk("sb_unexpected_done", 32'(done), 32'd0);
         end else begin
            chk("sb_done", 32'(done), 32'(sbq[0].done));
            chk("sb_rdata0", rdata0, (sbq[0].load && sbq[0].done[0]) ? sbq[0].data : exp_rd0);
            chk("sb_rdata1", rdata1, (sbq[0].load && sbq[0].done[1]) ? sbq[0].data : exp_rd1);
            if (sbq[0].load && sbq[0].done[0]) exp_rd0 <= sbq[0].data;
            if (sbq[0].load && sbq[0].done[1]) exp_rd1 <= sbq[0].data;
            void'(sbq.pop_front());
         end
      end
      if (!reset && |(gnt & ~req & ~done)) viol_cnt <= viol_cnt + 1;
   end

   task automatic drive(input int c, input logic w, input word_t a, input word_t d);
      if (c == 0) begin
         req0_r = 1'b1; we0_r = w; addr0 = a; wdata0 = d;
      end else begin
         req1_r = 1'b1; we1_r = w; addr1 = a; wdata1 = d;
      end
   endtask

   task automatic drop(input int c);
      if (c == 0) req0_r = 1'b0;
      else        req1_r = 1'b0;
   endtask

   task automatic wait_done(input int c);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!done[c] && n < 50);
      if (!done[c]) chk("wait_done_timeout", 32'(done), (c == 0) ? 32'd1 : 32'd2);
   endtask

   task automatic core_op(input int c, input logic w, input word_t a, input word_t d, input bit hold);
      drive(c, w, a, d);
      wait_done(c);
      if (!hold) drop(c);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      mem_init = 1'b1;
      reset    = 1'b1;
      req0_r = 1'b0; req1_r = 1'b0; we0_r = 1'b0; we1_r = 1'b0;
      addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
      req_l = 2'b00; we_l = 2'b00;
      for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
      repeat (3) @(negedge clk);
      mem_init = 1'b0;
      reset    = 1'b0;

      chk("rst_done", 32'(done), 32'd0);
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_mem_en", 32'(mem_en), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      chk("rst_rdata0", rdata0, 32'd0);
      chk("rst_rdata1", rdata1, 32'd0);

      // single load, MEM_LAT=1
      @(negedge clk);
      push_exp(0, 1'b0, 32'h40, 32'h0);
      drive(0, 1'b0, 32'h40, 32'h0);
      @(negedge clk);
      chk("t1_en_t1", 32'(mem_en), 32'd1);
      chk("t1_addr_t1", mem_addr, 32'h40);
      chk("t1_gnt_t1", 32'(gnt), 32'd1);
      chk("t1_done_t1", 32'(done), 32'd0);
      @(negedge clk);
      chk("t1_en_t2", 32'(mem_en), 32'd0);
      chk("t1_gnt_t2", 32'(gnt), 32'd1);
      chk("t1_done_t2", 32'(done), 32'd0);
      @(negedge clk);
      chk("t1_done_t3", 32'(done), 32'd1);
      chk("t1_gnt_t3", 32'(gnt), 32'd1);
      chk("t1_rdata0", rdata0, 32'hDEADBEEF);
      drop(0);
      @(negedge clk);
      chk("t1_done_t4", 32'(done), 32'd0);
      chk("t1_gnt_t4", 32'(gnt), 32'd0);

      // MEM_LAT=3 instance: done at t+5, capture only in the last WAIT cycle
      addr0 = 32'h40;
      req_l = 2'b01;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         chk($sformatf("t4_done_k%0d", k), 32'(done_l), (k == 5) ? 32'd1 : 32'd0);
         chk($sformatf("t4_rdata0_k%0d", k), rdata0_l, (k >= 5) ? 32'hDEADBEEF : 32'd0);
         if (k == 1) begin
            chk("t4_gnt", 32'(gnt_l), 32'd1);
            chk("t4_en", 32'(mem_en_l), 32'd1);
            chk("t4_addr", mem_addr_l, 32'h40);
         end
         if (k == 5) req_l = 2'b00;
      end
      chk("t4_rdata1", rdata1_l, 32'd0);

      // both cores held high from reset: strict alternation starting with core0
      do_reset();
      for (int k = 0; k < 3; k++) begin
         push_exp(0, 1'b0, 32'h100 + 32'(k * 8), 32'h0);
         push_exp(1, 1'b0, 32'h104 + 32'(k * 8), 32'h0);
      end
      fork
         begin
            for (int k = 0; k < 3; k++) core_op(0, 1'b0, 32'h100 + 32'(k * 8), 32'h0, k < 2);
         end
         begin
            for (int j = 0; j < 3; j++) core_op(1, 1'b0, 32'h104 + 32'(j * 8), 32'h0, j < 2);
         end
      join

      // store from core1, then read it back through core0
      @(negedge clk);
      push_exp(1, 1'b1, 32'h80, 32'h12345678);
      drive(1, 1'b1, 32'h80, 32'h12345678);
      @(negedge clk);
      chk("t3_en", 32'(mem_en), 32'd1);
      chk("t3_we", 32'(mem_we), 32'd1);
      chk("t3_addr", mem_addr, 32'h80);
      chk("t3_wdata", mem_wdata, 32'h12345678);
      wdata1 = 32'hFFFF0000;
      @(negedge clk);
      chk("t3_en_off", 32'(mem_en), 32'd0);
      chk("t3_wdata_hold", mem_wdata, 32'h12345678);
      @(negedge clk);
      chk("t3_done", 32'(done), 32'd2);
      drop(1);
      we1_r = 1'b0;
      @(negedge clk);
      push_exp(0, 1'b0, 32'h80, 32'h0);
      core_op(0, 1'b0, 32'h80, 32'h0, 1'b0);

      // reset while in WAIT: no done, state cleared, prio back to core0
      @(negedge clk);
      drive(0, 1'b0, 32'h60, 32'h0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("t5_gnt", 32'(gnt), 32'd0);
      chk("t5_done", 32'(done), 32'd0);
      chk("t5_rdata0", rdata0, 32'd0);
      chk("t5_rdata1", rdata1, 32'd0);
      chk("t5_mem_en", 32'(mem_en), 32'd0);
      chk("t5_mem_addr", mem_addr, 32'd0);
      drop(0);
      @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      push_exp(0, 1'b0, 32'h44, 32'h0);
      push_exp(1, 1'b0, 32'h48, 32'h0);
      fork
         core_op(0, 1'b0, 32'h44, 32'h0, 1'b0);
         core_op(1, 1'b0, 32'h48, 32'h0, 1'b0);
      join
      @(negedge clk);
      push_exp(1, 1'b0, 32'h4C, 32'h0);
      core_op(1, 1'b0, 32'h4C, 32'h0, 1'b0);

      // core1 arrives mid-access, core0 abandons its request in flight
      chk("t6_no_viol_yet", 32'(viol_cnt), 32'd0);
      @(negedge clk);
      push_exp(0, 1'b0, 32'h50, 32'h0);
      push_exp(1, 1'b0, 32'h54, 32'h0);
      drive(0, 1'b0, 32'h50, 32'h0);
      @(negedge clk);
      drive(1, 1'b0, 32'h54, 32'h0);
      drop(0);
      @(negedge clk);
      chk("t6_gnt_core0", 32'(gnt), 32'd1);
      chk("t6_addr_core0", mem_addr, 32'h50);
      wait_done(0);
      wait_done(1);
      drop(1);
      @(negedge clk);
      chk("t6_viol_flagged", 32'(viol_cnt != 0), 32'd1);

      repeat (2) @(negedge clk);
      chk("sb_empty", 32'(sbq.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
